// File: rtl/mod5_step_ctrl.sv
// Push-button front end for the mod-5 counter: sync, debounce, press edge, hold/lockout FSM.
// Define MOD5_STEP_AUTOREPEAT_EN to enable auto-repeat steps while a button is held.
module mod5_step_ctrl #(
  parameter int DB_CYCLES     = 4,
  parameter int DB_W          = 3,
  parameter int REPEAT_CYCLES = 8,
  parameter int RP_W          = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_up,
  input  logic btn_dn,
  output logic en,
  output logic up,
  output logic busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] UP_HELD = 2'd1;
  localparam logic [1:0] DN_HELD = 2'd2;
  localparam logic [1:0] LOCK    = 2'd3;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || (DB_CYCLES - 1) >= (1 << DB_W)) begin : g_bad_db
    $error("DB_W cannot hold DB_CYCLES-1");
  end
  if (REPEAT_CYCLES < 2 || (REPEAT_CYCLES - 1) >= (1 << RP_W)) begin : g_bad_rp
    $error("RP_W cannot hold REPEAT_CYCLES-1");
  end

  // bit 0 = up button, bit 1 = down button
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] db;
  logic [1:0] db_q;
  logic [1:0] press;
  logic [1:0] state;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1   <= '0;
      s2   <= '0;
      db_q <= '0;
    end else begin
      s1   <= {btn_dn, btn_up};
      s2   <= s1;
      db_q <= db;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        cnt   <= '0;
        db[i] <= 1'b0;
      end else if (s2[i] != db[i]) begin
        if (cnt == DB_LAST) begin
          db[i] <= ~db[i];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = db & ~db_q;
  assign busy  = (state != IDLE);

`ifdef MOD5_STEP_AUTOREPEAT_EN
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] rp;
  logic            held;
  logic            rp_hit;

  assign held   = (state == UP_HELD || state == DN_HELD) && (db != 2'b00);
  assign rp_hit = held && (rp == RP_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rp <= '0;
    end else if (!held || rp_hit) begin
      rp <= '0;
    end else begin
      rp <= rp + 1'b1;
    end
  end
`else
  logic rp_hit;
  assign rp_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      en    <= 1'b0;
      up    <= 1'b1;
    end else begin
      en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press == 2'b11) begin
            state <= LOCK;
          end else if (press[0]) begin
            en    <= 1'b1;
            up    <= 1'b1;
            state <= UP_HELD;
          end else if (press[1]) begin
            en    <= 1'b1;
            up    <= 1'b0;
            state <= DN_HELD;
          end
        end
        UP_HELD, DN_HELD: begin
          if (db == 2'b00) begin
            state <= IDLE;
          end else if (rp_hit) begin
            en <= 1'b1;
          end
        end
        LOCK: begin
          if (db == 2'b00) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod5_step_ctrl.sv
// Scoreboard bench for mod5_step_ctrl: expected steps queued at stimulus time,
// popped and checked against each en pulse.
module tb_mod5_step_ctrl;

  logic clk = 1'b0;
  logic clr;
  logic btn_up;
  logic btn_dn;
  logic en;
  logic up;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int   cyc;
    logic up;
  } exp_t;

  exp_t sb[$];
  logic en_prev = 1'b0;

  mod5_step_ctrl dut (
    .clk    (clk),
    .clr    (clr),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .en     (en),
    .up     (up),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // each en pulse is consumed against the oldest expected step
  always @(negedge clk) begin
    if (en) begin
      chk("en_double", {31'd0, en_prev}, 0);
      if (sb.size() == 0) begin
        chk("en_spurious", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("en_up", {31'd0, up}, {31'd0, e.up});
        chk("en_cycle", cyc, e.cyc);
      end
    end
    en_prev <= en;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // press driven at the current negedge: step seen at cycle now+7
  task automatic expect_step(input int at, input logic dir);
    exp_t e;
    e.cyc = at;
    e.up  = dir;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      step(1);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic settle(input string tag);
    step(15);
    chk(tag, {31'd0, busy}, 0);
    drain({tag, "_sb"});
  endtask

  initial begin
    int c;
    clr    = 1'b1;
    btn_up = 1'b1;
    btn_dn = 1'b0;
    step(3);
    chk("rst_en", {31'd0, en}, 0);
    chk("rst_up", {31'd0, up}, 1);
    chk("rst_busy", {31'd0, busy}, 0);

    // button held through reset release re-debounces into one step
    c   = cyc;
    clr = 1'b0;
    expect_step(c + 7, 1'b1);
    step(20);
    chk("rst_hold_busy", {31'd0, busy}, 1);
    btn_up = 1'b0;
    settle("rst_rel");

    // clean press with exact latency
    c      = cyc;
    btn_up = 1'b1;
    expect_step(c + 7, 1'b1);
    step(10);
    chk("clean_busy", {31'd0, busy}, 1);
    step(10);
    btn_up = 1'b0;
    settle("clean_rel");
    chk("clean_up_hold", {31'd0, up}, 1);

    // bouncy down press: three 3-cycle pulses, then stable
    for (int i = 0; i < 3; i++) begin
      btn_dn = 1'b1;
      step(3);
      btn_dn = 1'b0;
      step(1);
    end
    c      = cyc;
    btn_dn = 1'b1;
    expect_step(c + 7, 1'b0);
    step(12);
    btn_dn = 1'b0;
    settle("bounce_rel");
    chk("bounce_up_hold", {31'd0, up}, 0);

    // simultaneous press locks out
    btn_up = 1'b1;
    btn_dn = 1'b1;
    step(12);
    chk("lock_busy", {31'd0, busy}, 1);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    settle("lock_rel");
    c      = cyc;
    btn_up = 1'b1;
    expect_step(c + 7, 1'b1);
    step(12);
    btn_up = 1'b0;
    settle("after_lock");

    // down pressed while up held is ignored
    c      = cyc;
    btn_up = 1'b1;
    expect_step(c + 7, 1'b1);
    step(10);
    btn_dn = 1'b1;
    step(10);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    settle("held_rel");
    c      = cyc;
    btn_dn = 1'b1;
    expect_step(c + 7, 1'b0);
    step(12);
    btn_dn = 1'b0;
    settle("held_dn");

    // long hold: repeats every 8 cycles only when auto-repeat is built in
    c      = cyc;
    btn_up = 1'b1;
    expect_step(c + 7, 1'b1);
`ifdef MOD5_STEP_AUTOREPEAT_EN
    expect_step(c + 15, 1'b1);
    expect_step(c + 23, 1'b1);
    expect_step(c + 31, 1'b1);
`endif
    step(31);
    btn_up = 1'b0;
    settle("repeat_rel");

    // reset in mid-press aborts it without a step
    btn_dn = 1'b1;
    step(4);
    clr = 1'b1;
    step(2);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_up", {31'd0, up}, 1);
    btn_dn = 1'b0;
    clr    = 1'b0;
    settle("abort_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
